// File: rtl/game_pkg.sv
// Shared constants for the game controller: clock rate, default timing windows
// and the goal sensor FSM state encoding.
package game_pkg;

    localparam int CLK_HZ     = 100_000_000;
    localparam int CYC_PER_MS = CLK_HZ / 1000;

    localparam int DEBOUNCE_MS = 10;
    localparam int LOCKOUT_MS  = 200;
    localparam int STUCK_MS    = 3000;

    localparam int DEF_DEBOUNCE_CYC = DEBOUNCE_MS * CYC_PER_MS;
    localparam int DEF_LOCKOUT_CYC  = LOCKOUT_MS  * CYC_PER_MS;
    localparam int DEF_STUCK_CYC    = STUCK_MS    * CYC_PER_MS;

    typedef logic [2:0] gs_state_t;

    localparam gs_state_t GS_IDLE    = 3'd0;
    localparam gs_state_t GS_QUAL    = 3'd1;
    localparam gs_state_t GS_BLOCKED = 3'd2;
    localparam gs_state_t GS_LOCKOUT = 3'd3;
    localparam gs_state_t GS_STUCK   = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with a selectable reset level, shared by
// the goal sensors and the start/stop/back buttons.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: reset to the input's idle level so release never looks like an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= rst_val;
            sync_q <= rst_val;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/goal_sensor_filter.sv
// Turns the raw hoop beam-break sensor into a single-cycle goal pulse, with
// debounce, re-arm lockout, stuck-sensor detection and a saturating goal tally.
module goal_sensor_filter
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int LOCKOUT_CYC   = DEF_LOCKOUT_CYC,
    parameter int STUCK_CYC     = DEF_STUCK_CYC,
    parameter bit SENSOR_ACT_LO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_raw,
    input  logic       enable,
    input  logic       clr_cnt,
    output logic       goal,
    output logic       blocked,
    output logic       stuck,
    output logic [7:0] goal_cnt
);

    localparam int TW = $clog2(max3(DEBOUNCE_CYC, LOCKOUT_CYC, STUCK_CYC)) + 1;

    localparam logic [TW-1:0] DEB_LAST   = TW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] STUCK_LAST = TW'(STUCK_CYC - 1);

    logic          sync_raw;
    logic          blk_q,     blk_d;
    gs_state_t     state_q,   state_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic          goal_q,    goal_d;
    logic          blocked_q, blocked_d;
    logic          stuck_q,   stuck_d;
    logic [7:0]    cnt_q,     cnt_d;

    // The clear level of the pin is the reset value, so reset reads as "beam clear".
    sync_2ff u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (SENSOR_ACT_LO),
        .d       (sensor_raw),
        .q       (sync_raw)
    );

    assign blk_d = sync_raw ^ SENSOR_ACT_LO;

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        goal_d  = 1'b0;
        unique case (state_q)
            GS_IDLE: begin
                if (blk_q) state_d = GS_QUAL;
            end
            GS_QUAL: begin
                if (!blk_q) begin
                    state_d = GS_IDLE;
                end else if (timer_q == DEB_LAST) begin
                    state_d = GS_BLOCKED;
                    goal_d  = enable;
                end
            end
            GS_BLOCKED: begin
                if (!blk_q)                     state_d = GS_LOCKOUT;
                else if (timer_q == STUCK_LAST) state_d = GS_STUCK;
            end
            GS_LOCKOUT: begin
                if (blk_q)                     state_d = GS_BLOCKED;
                else if (timer_q == LOCK_LAST) state_d = GS_IDLE;
            end
            GS_STUCK: begin
                if (!blk_q) state_d = GS_LOCKOUT;
            end
            default: state_d = GS_IDLE;
        endcase
    end

    always_comb begin
        timer_d = '0;
        if (state_d == state_q &&
            (state_q == GS_QUAL || state_q == GS_BLOCKED || state_q == GS_LOCKOUT))
            timer_d = timer_q + 1'b1;

        blocked_d = (state_d == GS_BLOCKED) || (state_d == GS_STUCK);
        stuck_d   = (state_d == GS_STUCK);

        cnt_d = cnt_q;
        if (clr_cnt)                      cnt_d = 8'd0;
        else if (goal_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    // NOTE: sequential state is assigned non-blocking only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q     <= 1'b0;
            state_q   <= GS_IDLE;
            timer_q   <= '0;
            goal_q    <= 1'b0;
            blocked_q <= 1'b0;
            stuck_q   <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            blk_q     <= blk_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            goal_q    <= goal_d;
            blocked_q <= blocked_d;
            stuck_q   <= stuck_d;
            cnt_q     <= cnt_d;
        end
    end

    assign goal     = goal_q;
    assign blocked  = blocked_q;
    assign stuck    = stuck_q;
    assign goal_cnt = cnt_q;

endmodule

// File: tb/tb_goal_sensor_filter.sv
// Directed bench for goal_sensor_filter with short timing windows
// (debounce 4, lockout 8, stuck 32, active-low sensor).
module tb_goal_sensor_filter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sensor_raw;
    logic       enable;
    logic       clr_cnt;
    logic       goal;
    logic       blocked;
    logic       stuck;
    logic [7:0] goal_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    goal_sensor_filter #(
        .DEBOUNCE_CYC  (4),
        .LOCKOUT_CYC   (8),
        .STUCK_CYC     (32),
        .SENSOR_ACT_LO (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_raw (sensor_raw),
        .enable     (enable),
        .clr_cnt    (clr_cnt),
        .goal       (goal),
        .blocked    (blocked),
        .stuck      (stuck),
        .goal_cnt   (goal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (goal === 1'b1) pulses++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic goal_once();
        sensor_raw = 1'b0;
        run(10);
        sensor_raw = 1'b1;
        run(15);
    endtask

    initial begin
        int first_goal;
        int first_stuck;
        int blk_seen;
        bit hit;

        rst_n      = 1'b0;
        sensor_raw = 1'b1;
        enable     = 1'b1;
        clr_cnt    = 1'b0;
        #12;
        check("rst_goal",    goal,     0);
        check("rst_blocked", blocked,  0);
        check("rst_stuck",   stuck,    0);
        check("rst_cnt",     goal_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(5);

        // 1: clean goal; pulse 7 cycles after the first sampling edge (tick 1)
        pulses = 0; first_goal = -1;
        sensor_raw = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (goal === 1'b1 && first_goal < 0) first_goal = k - 1;
        end
        check("t1_latency", first_goal, 7);
        check("t1_pulses",  pulses,     1);
        check("t1_blocked", blocked,    1);
        check("t1_cnt",     goal_cnt,   1);
        sensor_raw = 1'b1;
        run(15);
        check("t1_unblock", blocked, 0);

        // 2: 3-cycle glitch never qualifies
        pulses = 0; blk_seen = 0;
        sensor_raw = 1'b0;
        run(3);
        sensor_raw = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (blocked === 1'b1) blk_seen = 1;
        end
        check("t2_pulses",  pulses,   0);
        check("t2_blocked", blk_seen, 0);
        check("t2_cnt",     goal_cnt, 1);

        // 3: re-block inside lockout is a rattle, not a new goal
        pulses = 0;
        sensor_raw = 1'b0; run(10);
        sensor_raw = 1'b1; run(5);
        sensor_raw = 1'b0; run(10);
        sensor_raw = 1'b1; run(12);
        check("t3_rattle_pulses", pulses,   1);
        check("t3_rattle_cnt",    goal_cnt, 2);
        sensor_raw = 1'b0; run(10);
        check("t3_second_pulses", pulses,   2);
        check("t3_second_cnt",    goal_cnt, 3);
        sensor_raw = 1'b1; run(15);

        // 4: stuck sensor; STUCK entered 32 cycles after BLOCKED (edge 39)
        pulses = 0; first_stuck = -1;
        sensor_raw = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (stuck === 1'b1 && first_stuck < 0) first_stuck = k - 1;
        end
        check("t4_stuck_at",  first_stuck, 39);
        check("t4_stuck",     stuck,       1);
        check("t4_blocked",   blocked,     1);
        check("t4_pulses",    pulses,      1);
        sensor_raw = 1'b1; run(15);
        check("t4_unstuck",   stuck,   0);
        check("t4_unblocked", blocked, 0);
        sensor_raw = 1'b0; run(10);
        check("t4_rearm_pulses", pulses,   2);
        check("t4_rearm_cnt",    goal_cnt, 5);
        sensor_raw = 1'b1; run(15);

        // 5: enable low through qualification, raised while still blocked
        pulses = 0;
        enable = 1'b0;
        sensor_raw = 1'b0;
        run(9);
        enable = 1'b1;
        run(11);
        check("t5_pulses",  pulses,   0);
        check("t5_cnt",     goal_cnt, 5);
        check("t5_blocked", blocked,  1);
        sensor_raw = 1'b1; run(15);

        // 6: saturation, clear priority, async reset mid-pulse
        pulses = 0;
        for (int g = 0; g < 260; g++) goal_once();
        check("t6_pulses",   pulses,   260);
        check("t6_saturate", goal_cnt, 255);

        sensor_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            clr_cnt = goal;
        end
        clr_cnt = 1'b0;
        sensor_raw = 1'b1; run(15);
        check("t6_clr_at_sat", goal_cnt, 0);

        goal_once();
        check("t6_inc_after_clr", goal_cnt, 1);
        sensor_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            clr_cnt = goal;
        end
        clr_cnt = 1'b0;
        sensor_raw = 1'b1; run(15);
        check("t6_clr_priority", goal_cnt, 0);

        goal_once();
        check("t6_cnt_pre_rst", goal_cnt, 1);
        hit = 1'b0;
        sensor_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (goal === 1'b1 && !hit) begin
                hit = 1'b1;
                rst_n = 1'b0;
                #1;
                check("t6_rst_goal",    goal,     0);
                check("t6_rst_blocked", blocked,  0);
                check("t6_rst_stuck",   stuck,    0);
                check("t6_rst_cnt",     goal_cnt, 0);
            end
        end
        check("t6_rst_hit", hit, 1);
        sensor_raw = 1'b1;
        run(2);
        rst_n = 1'b1;
        pulses = 0;
        run(15);
        check("t6_no_replay", pulses,   0);
        check("t6_post_cnt",  goal_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
